// File: rtl/program_loader_if.sv
// program_loader_if
//   Groups the byte-stream link and the instruction-memory write port of
//   the program loader.
//
//   Byte link handshake: a byte moves on a rising clk edge where
//   byte_valid=1 and byte_ready=1, exactly one byte per such edge.
//   The source must hold byte_data stable while byte_valid=1 and
//   byte_ready=0. byte_ready is registered and does not depend on
//   byte_valid.
//
//   Modports:
//     master - host/bench side: drives the byte link, observes the writes.
//     slave  - loader side: accepts bytes, drives the imem write port.
`timescale 1ns/1ps
interface program_loader_if #(
  parameter int ADDR_W = 64
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// program_loader
//   Streams a program image in over a byte-wide valid/ready link and
//   writes it into instruction memory as 32-bit little-endian words,
//   holding the processor in reset until the load completes.
//
//   Image: 16-bit little-endian word count N, then N words LSB first.
//   N=0 finishes immediately; N>DEPTH_WORDS is rejected (sticky error).
//
//   Ports:
//     clk        - system clock, rising edge
//     reset      - asynchronous active-low reset
//     start      - one-cycle pulse, honoured in IDLE, DONE, ERR
//     bus        - byte link + imem write port (program_loader_if.slave)
//     cpu_reset  - active-high reset to the processor
//     done       - load completed (sticky until next start)
//     error      - length rejected (sticky until next start)
//     dbg_state  - current FSM state encoding, for observation only
`timescale 1ns/1ps
module program_loader #(
  parameter int DEPTH_WORDS = 16,
  parameter int ADDR_W      = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  program_loader_if.slave        bus,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t            state_q;
  logic              byte_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              cpu_reset_q;
  logic              done_q;
  logic              error_q;
  logic [7:0]        len_lo_q;
  logic [15:0]       words_left_q;
  logic [1:0]        byte_idx_q;
  // Holds the first three bytes of a word; byte 0 ends up in the low lane.
  logic [23:0]       shreg_q;

  logic              xfer;
  logic [15:0]       n_hdr;

  assign xfer  = bus.byte_valid & byte_ready_q;
  // Full word count as it will be once the high byte lands this cycle.
  assign n_hdr = {bus.byte_data, len_lo_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      len_lo_q     <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      shreg_q      <= '0;
    end else begin
      // The write strobe is only ever high for the single WRITE cycle.
      imem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_LEN_LO;
            byte_ready_q <= 1'b1;
            imem_addr_q  <= '0;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_lo_q <= bus.byte_data;
            state_q  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            if (n_hdr == 16'd0) begin
              state_q      <= S_DONE;
              byte_ready_q <= 1'b0;
              done_q       <= 1'b1;
              cpu_reset_q  <= 1'b0;
            end else if (n_hdr > 16'(DEPTH_WORDS)) begin
              state_q      <= S_ERR;
              byte_ready_q <= 1'b0;
              error_q      <= 1'b1;
            end else begin
              state_q      <= S_DATA;
              words_left_q <= n_hdr;
              byte_idx_q   <= '0;
              imem_addr_q  <= '0;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              // Fourth byte completes the word; drop ready so no byte
              // is taken during the write cycle.
              state_q      <= S_WRITE;
              byte_ready_q <= 1'b0;
              imem_we_q    <= 1'b1;
              imem_wdata_q <= {bus.byte_data, shreg_q};
            end else begin
              shreg_q <= {bus.byte_data, shreg_q[23:8]};
            end
          end
        end
        S_WRITE: begin
          imem_addr_q  <= imem_addr_q + ADDR_W'(4);
          words_left_q <= words_left_q - 16'd1;
          byte_idx_q   <= '0;
          if (words_left_q == 16'd1) begin
            state_q      <= S_DONE;
            byte_ready_q <= 1'b0;
            done_q       <= 1'b1;
            cpu_reset_q  <= 1'b0;
          end else begin
            state_q      <= S_DATA;
            byte_ready_q <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            state_q      <= S_LEN_LO;
            byte_ready_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_reset_q  <= 1'b1;
            imem_addr_q  <= '0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          byte_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign done           = done_q;
  assign error          = error_q;
  assign dbg_state      = state_q;

endmodule
